// File: rtl/gb_dma_engine.sv
// OAM-style DMA engine: copies LEN bytes from {page, idx} to DST_BASE+idx,
// one byte every RD_CYC+1 cycles, started (or restarted) by a register write.
module gb_dma_engine #(
    parameter int PAGE_W    = 8,
    parameter int IDX_W     = 8,
    parameter int LEN       = 160,
    parameter int RD_CYC    = 3,
    parameter int START_DLY = 1,
    parameter int DST_BASE  = 0
) (
    input  logic                    clk_i,
    input  logic                    n_reset_i,
    input  logic                    reg_write_i,
    input  logic [PAGE_W-1:0]       reg_din_i,
    output logic [PAGE_W-1:0]       reg_dout_o,
    output logic [PAGE_W+IDX_W-1:0] adr_rd_o,
    output logic                    rd_o,
    input  logic [7:0]              din_i,
    input  logic                    src_int_i,
    output logic [IDX_W-1:0]        adr_wr_o,
    output logic                    wr_o,
    output logic [7:0]              dout_o,
    output logic                    active_o,
    output logic                    drv_ext_o,
    output logic [1:0]              dbg_state_o
);

    localparam int CNT_MAX = (RD_CYC > START_DLY) ? RD_CYC : START_DLY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RD_INIT  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_INIT = CNT_W'(START_DLY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [IDX_W-1:0] BASE     = IDX_W'(DST_BASE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_READ  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PAGE_W-1:0]       page_q, page_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              data_q, data_d;
    logic                    rd_q, wr_q, active_q, own_q;
    logic [PAGE_W+IDX_W-1:0] adr_rd_q;
    logic [IDX_W-1:0]        adr_wr_q;

    // A register write wins over every state: it reloads the page and restarts.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (reg_write_i) begin
            page_d  = reg_din_i;
            idx_d   = '0;
            cnt_d   = DLY_INIT;
            state_d = S_DELAY;
        end else begin
            case (state_q)
                S_DELAY: begin
                    if (cnt_q == '0) begin
                        cnt_d   = RD_INIT;
                        state_d = S_READ;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_READ: begin
                    if (cnt_q == '0) begin
                        data_d  = din_i;
                        state_d = S_WRITE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = RD_INIT;
                        state_d = S_READ;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (!n_reset_i) begin
            state_q  <= S_IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            active_q <= 1'b0;
            own_q    <= 1'b0;
            adr_rd_q <= '0;
            adr_wr_q <= '0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            rd_q     <= (state_d == S_READ);
            wr_q     <= (state_d == S_WRITE);
            active_q <= (state_d != S_IDLE);
            own_q    <= (state_d == S_READ) || (state_d == S_WRITE);
            adr_rd_q <= (state_d == S_READ) ? {page_d, idx_d} : '0;
            adr_wr_q <= (state_d == S_WRITE) ? (idx_d + BASE) : '0;
        end
    end

    // src_int is the memmap decode of adr_rd, so the pin release follows it directly.
    assign drv_ext_o   = own_q & ~src_int_i;
    assign rd_o        = rd_q;
    assign wr_o        = wr_q;
    assign active_o    = active_q;
    assign adr_rd_o    = adr_rd_q;
    assign adr_wr_o    = adr_wr_q;
    assign dout_o      = data_q;
    assign reg_dout_o  = page_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gb_dma_engine.sv
// Bench for gb_dma_engine: a timeline model (cycles since the register write)
// is compared against two DUTs (default and short/wrapping config) every cycle.
module tb_gb_dma_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // DUT A: default parameters
    logic        n_reset_a, reg_write_a, src_int_a;
    logic [7:0]  reg_din_a, reg_dout_a, din_a, dout_a, adr_wr_a;
    logic [15:0] adr_rd_a;
    logic        rd_a, wr_a, active_a, drv_ext_a;
    logic [1:0]  state_a;

    // DUT B: LEN=4, RD_CYC=1, DST_BASE=0xFE
    logic        n_reset_b, reg_write_b, src_int_b;
    logic [7:0]  reg_din_b, reg_dout_b, din_b, dout_b, adr_wr_b;
    logic [15:0] adr_rd_b;
    logic        rd_b, wr_b, active_b, drv_ext_b;
    logic [1:0]  state_b;

    function automatic logic [7:0] ext_f(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] vram_f(input logic [15:0] a);
        return ~a[7:0] + a[15:8];
    endfunction

    function automatic logic [7:0] src_f(input logic [15:0] a, input logic s);
        return s ? vram_f(a) : ext_f(a);
    endfunction

    assign din_a = src_f(adr_rd_a, src_int_a);
    assign din_b = src_f(adr_rd_b, src_int_b);

    gb_dma_engine dut_a (
        .clk_i(clk), .n_reset_i(n_reset_a), .reg_write_i(reg_write_a),
        .reg_din_i(reg_din_a), .reg_dout_o(reg_dout_a), .adr_rd_o(adr_rd_a),
        .rd_o(rd_a), .din_i(din_a), .src_int_i(src_int_a), .adr_wr_o(adr_wr_a),
        .wr_o(wr_a), .dout_o(dout_a), .active_o(active_a), .drv_ext_o(drv_ext_a),
        .dbg_state_o(state_a)
    );

    gb_dma_engine #(.LEN(4), .RD_CYC(1), .START_DLY(1), .DST_BASE(8'hFE)) dut_b (
        .clk_i(clk), .n_reset_i(n_reset_b), .reg_write_i(reg_write_b),
        .reg_din_i(reg_din_b), .reg_dout_o(reg_dout_b), .adr_rd_o(adr_rd_b),
        .rd_o(rd_b), .din_i(din_b), .src_int_i(src_int_b), .adr_wr_o(adr_wr_b),
        .wr_o(wr_b), .dout_o(dout_b), .active_o(active_b), .drv_ext_o(drv_ext_b),
        .dbg_state_o(state_b)
    );

    // Model: a transfer is a timeline; k counts cycles since the register write.
    typedef struct packed { int len; int rdc; int sdl; int base; } cfg_t;
    typedef struct packed { bit run; int k; logic [7:0] page; logic [7:0] dq; } mdl_t;
    typedef struct packed { logic rd; logic wr; logic act; logic drv; logic [15:0] ar; logic [7:0] aw; } outs_t;

    cfg_t cfg_a = '{len: 160, rdc: 3, sdl: 1, base: 0};
    cfg_t cfg_b = '{len: 4, rdc: 1, sdl: 1, base: 254};
    mdl_t m_a = '0;
    mdl_t m_b = '0;

    function automatic mdl_t model_step(input mdl_t m, input cfg_t c, input logic nrst,
                                        input logic rw, input logic [7:0] pg, input logic src);
        mdl_t n = m;
        int o, b, p;
        if (!nrst) return '0;
        if (m.run && m.k > c.sdl && !rw) begin
            o = m.k - c.sdl - 1;
            b = o / (c.rdc + 1);
            p = o % (c.rdc + 1);
            if (b < c.len && p == c.rdc - 1) n.dq = src_f({m.page, 8'(b)}, src);
        end
        if (rw) begin
            n.page = pg;
            n.run  = 1'b1;
            n.k    = 1;
        end else if (m.run) begin
            n.k = m.k + 1;
            if (n.k > c.sdl + c.len * (c.rdc + 1)) begin
                n.run = 1'b0;
                n.k   = 0;
            end
        end
        return n;
    endfunction

    function automatic outs_t model_outs(input mdl_t m, input cfg_t c, input logic src);
        outs_t e = '0;
        int o, b, p;
        e.act = m.run;
        if (m.run && m.k > c.sdl) begin
            o = m.k - c.sdl - 1;
            b = o / (c.rdc + 1);
            p = o % (c.rdc + 1);
            if (b < c.len) begin
                if (p < c.rdc) begin
                    e.rd = 1'b1;
                    e.ar = {m.page, 8'(b)};
                end else begin
                    e.wr = 1'b1;
                    e.aw = 8'((c.base + b) % 256);
                end
            end
        end
        e.drv = (e.rd | e.wr) & ~src;
        return e;
    endfunction

    always @(posedge clk) begin
        m_a <= model_step(m_a, cfg_a, n_reset_a, reg_write_a, reg_din_a, src_int_a);
        m_b <= model_step(m_b, cfg_b, n_reset_b, reg_write_b, reg_din_b, src_int_b);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Logs of observed write pulses, used by the directed literal checks.
    logic [7:0] wr_adr_a[$], wr_dat_a[$], wr_adr_b[$];
    int         wr_cyc_a[$], wr_cyc_b[$];
    int         act_cnt_a = 0, drv_cnt_a = 0, rd_cnt_a = 0;

    always @(negedge clk) begin : cmp
        outs_t ea, eb;
        if (chk_en) begin
            ea = model_outs(m_a, cfg_a, src_int_a);
            eb = model_outs(m_b, cfg_b, src_int_b);
            chk("a.rd", rd_a, ea.rd);
            chk("a.adr_rd", adr_rd_a, ea.ar);
            chk("a.wr", wr_a, ea.wr);
            chk("a.adr_wr", adr_wr_a, ea.aw);
            chk("a.active", active_a, ea.act);
            chk("a.drv_ext", drv_ext_a, ea.drv);
            chk("a.dout", dout_a, m_a.dq);
            chk("a.reg_dout", reg_dout_a, m_a.page);
            chk("b.rd", rd_b, eb.rd);
            chk("b.adr_rd", adr_rd_b, eb.ar);
            chk("b.wr", wr_b, eb.wr);
            chk("b.adr_wr", adr_wr_b, eb.aw);
            chk("b.active", active_b, eb.act);
            chk("b.drv_ext", drv_ext_b, eb.drv);
            chk("b.dout", dout_b, m_b.dq);
            chk("b.reg_dout", reg_dout_b, m_b.page);
            if (wr_a) begin
                wr_adr_a.push_back(adr_wr_a);
                wr_dat_a.push_back(dout_a);
                wr_cyc_a.push_back(cyc);
            end
            if (wr_b) begin
                wr_adr_b.push_back(adr_wr_b);
                wr_cyc_b.push_back(cyc);
            end
            if (active_a)  act_cnt_a++;
            if (drv_ext_a) drv_cnt_a++;
            if (rd_a)      rd_cnt_a++;
        end
    end

    // Inputs change 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] pg);
        reg_din_a   = pg;
        reg_write_a = 1'b1;
        step(1);
        reg_write_a = 1'b0;
    endtask

    task automatic wait_adr_a(input logic [15:0] a, input int budget, input string nm);
        for (int i = 0; i < budget && adr_rd_a !== a; i++) step(1);
        chk(nm, adr_rd_a, a);
    endtask

    task automatic wait_last_wr_a(input int budget);
        for (int i = 0; i < budget && !(wr_a === 1'b1 && adr_wr_a === 8'h9F); i++) step(1);
        chk("t6.reach_last_wr", {wr_a, adr_wr_a}, {1'b1, 8'h9F});
    endtask

    logic [7:0] exp_q[$];
    int base, act0, drv0, rd0, bad;

    initial begin
        n_reset_a = 1'b0; reg_write_a = 1'b0; reg_din_a = '0; src_int_a = 1'b0;
        n_reset_b = 1'b0; reg_write_b = 1'b0; reg_din_b = '0; src_int_b = 1'b0;
        step(2);
        chk_en = 1'b1;
        step(1);
        n_reset_a = 1'b1;
        n_reset_b = 1'b1;
        chk("reset.active", active_a, 1'b0);
        chk("reset.reg_dout", reg_dout_a, 8'h00);
        chk("reset.state_a", state_a, 2'd0);
        chk("reset.state_b", state_b, 2'd0);
        step(2);

        // 1: full transfer from the external bus, page 0xC1
        base = wr_adr_a.size(); act0 = act_cnt_a; drv0 = drv_cnt_a;
        pulse_a(8'hC1);
        step(700);
        chk("t1.wr_count", wr_adr_a.size() - base, 160);
        bad = 0;
        for (int i = 0; i < 160 && base + i < wr_adr_a.size(); i++)
            if (wr_adr_a[base + i] !== 8'(i)) bad++;
        chk("t1.adr_wr_seq", bad, 0);
        if (wr_adr_a.size() >= base + 160) begin
            chk("t1.first_dout", wr_dat_a[base], 8'h20);
            chk("t1.last_dout", wr_dat_a[base + 159], 8'hBF);
        end
        chk("t1.active_cycles", act_cnt_a - act0, 641);
        chk("t1.drv_cycles", drv_cnt_a - drv0, 640);

        // 2: VRAM source keeps the external pins released
        base = wr_adr_a.size(); drv0 = drv_cnt_a; rd0 = rd_cnt_a;
        src_int_a = 1'b1;
        pulse_a(8'h80);
        step(700);
        chk("t2.drv_cycles", drv_cnt_a - drv0, 0);
        chk("t2.rd_cycles", rd_cnt_a - rd0, 480);
        chk("t2.wr_count", wr_adr_a.size() - base, 160);
        if (wr_adr_a.size() > base) chk("t2.first_dout", wr_dat_a[base], 8'h7F);
        src_int_a = 1'b0;

        // 3: restart with page 0xD0 in the first READ cycle of byte 50
        base = wr_adr_a.size();
        pulse_a(8'hC1);
        wait_adr_a(16'hC132, 400, "t3.reach_byte50");
        pulse_a(8'hD0);
        step(700);
        chk("t3.wr_count", wr_adr_a.size() - base, 210);
        if (wr_adr_a.size() >= base + 51) begin
            chk("t3.last_old_adr", wr_adr_a[base + 49], 8'h31);
            chk("t3.first_new_adr", wr_adr_a[base + 50], 8'h00);
            chk("t3.first_new_dout", wr_dat_a[base + 50], 8'h31);
            chk("t3.restart_gap", wr_cyc_a[base + 50] - wr_cyc_a[base + 49], 6);
        end

        // 4: one-cycle reset during byte 10
        base = wr_adr_a.size();
        pulse_a(8'h42);
        wait_adr_a(16'h420A, 200, "t4.reach_byte10");
        n_reset_a = 1'b0;
        step(1);
        n_reset_a = 1'b1;
        chk("t4.active", active_a, 1'b0);
        chk("t4.drv_ext", drv_ext_a, 1'b0);
        chk("t4.rd", rd_a, 1'b0);
        chk("t4.wr", wr_a, 1'b0);
        chk("t4.reg_dout", reg_dout_a, 8'h00);
        chk("t4.state", state_a, 2'd0);
        step(100);
        chk("t4.wr_count", wr_adr_a.size() - base, 10);

        // 5: short config with destination wrap
        base = wr_adr_b.size();
        reg_din_b = 8'h12; reg_write_b = 1'b1;
        step(1);
        reg_write_b = 1'b0;
        step(20);
        exp_q = {8'hFE, 8'hFF, 8'h00, 8'h01};
        chk("t5.wr_count", wr_adr_b.size() - base, 4);
        for (int i = 0; i < 4 && base + i < wr_adr_b.size(); i++) begin
            chk("t5.adr_wr", wr_adr_b[base + i], exp_q.pop_front());
            if (i > 0) chk("t5.wr_spacing", wr_cyc_b[base + i] - wr_cyc_b[base + i - 1], 2);
        end

        // 6: register write on the final WRITE cycle
        base = wr_adr_a.size();
        pulse_a(8'h5A);
        wait_last_wr_a(800);
        pulse_a(8'h33);
        step(700);
        chk("t6.wr_count", wr_adr_a.size() - base, 320);
        if (wr_adr_a.size() >= base + 161) begin
            chk("t6.final_adr", wr_adr_a[base + 159], 8'h9F);
            chk("t6.new_first_adr", wr_adr_a[base + 160], 8'h00);
            chk("t6.new_first_dout", wr_dat_a[base + 160], 8'h0F);
            chk("t6.restart_gap", wr_cyc_a[base + 160] - wr_cyc_a[base + 159], 5);
        end

        // Random phase: random pages, sources, restart points and resets
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                n_reset_a = 1'b0;
                n_reset_b = 1'b0;
                step(1);
                n_reset_a = 1'b1;
                n_reset_b = 1'b1;
            end
            src_int_a   = 1'($urandom_range(0, 1));
            src_int_b   = 1'($urandom_range(0, 1));
            reg_din_a   = 8'($urandom_range(0, 255));
            reg_din_b   = 8'($urandom_range(0, 255));
            reg_write_a = 1'b1;
            reg_write_b = 1'($urandom_range(0, 1));
            step(1);
            reg_write_a = 1'b0;
            reg_write_b = 1'b0;
            step($urandom_range(1, 700));
        end
        step(700);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
